// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU (alu_ctrl 1=add, 0=Q1.7 multiply)
// between two requesters. One operation is in flight at a time and each one
// takes at least three cycles: IDLE (grant), EXEC (ALU evaluates), RESP (hold
// the result until it is accepted).
// The default build uses round-robin arbitration. Defining ALU_ARB_FIXED_PRIO_EN
// switches to fixed priority, where port 0 always wins contention.
module alu_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             alu_ctrl,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             busy_q, busy_d;
  logic             grant_c;

  // Arbitration: pick the port to serve this cycle from the current requests
  always_comb begin
    grant_c = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant_c = ~req_valid[0];
`else
    if (req_valid == 2'b11) begin
      grant_c = ~last_grant_q;
    end else begin
      grant_c = ~req_valid[0];
    end
`endif
  end

  // Next-state, operand capture and handshake logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    req_ready    = 2'b00;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready    = grant_c ? 2'b10 : 2'b01;
          grant_d      = grant_c;
          last_grant_d = grant_c;
          op_d         = req_op[grant_c];
          a_d          = grant_c ? req_a1 : req_a0;
          b_d          = grant_c ? req_b1 : req_b0;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = alu_result;
        rsp_valid_d = grant_q ? 2'b10 : 2'b01;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 2'b00;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; last_grant resets to 1 so port 0 wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
    end
  end

  // The ALU always sees the operand registers; they only change on a grant
  assign alu_ctrl  = op_q;
  assign alu_in1   = a_q;
  assign alu_in2   = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model plus directed cases
// (add, Q1.7 multiply, wrap, grant order, response stall, reset in EXEC) and a
// randomized phase. Honours ALU_ARB_FIXED_PRIO_EN the same way as the design.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid, req_ready, req_op, rsp_valid, rsp_ready;
  logic [7:0] req_a0, req_b0, req_a1, req_b1, rsp_data;
  logic       alu_ctrl, busy;
  logic [7:0] alu_in1, alu_in2, alu_result;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_ctrl(alu_ctrl), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Combinational ALU stub: add wraps, multiply keeps product bits [14:7]
  logic signed [15:0] prod;
  always_comb begin
    prod       = $signed(alu_in1) * $signed(alu_in2);
    alu_result = alu_ctrl ? 8'(alu_in1 + alu_in2) : prod[14:7];
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_alu(input bit op, input logic [7:0] a, input logic [7:0] b);
    int p;
    if (op) return 8'((int'(a) + int'(b)) % 256);
    p = int'($signed(a)) * int'($signed(b));
    return 8'(p >>> 7);
  endfunction

  function automatic bit pick(input logic [1:0] v, input bit last);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v[0] ? 1'b0 : 1'b1;
`else
    if (v == 2'b11) return ~last;
    return v[0] ? 1'b0 : 1'b1;
`endif
  endfunction

  // Reference model: one transaction record with its age since grant
  bit         m_busy, m_port, m_last, m_op;
  int         m_age;
  logic [7:0] m_a, m_b, m_res, m_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_last = 1; m_op = 1; m_a = 0; m_b = 0; m_age = 0;
      m_data = 0; m_port = 0; m_res = 0;
    end else if (!m_busy) begin
      if (req_valid != 2'b00) begin
        m_port = pick(req_valid, m_last);
        m_last = m_port;
        m_op   = req_op[m_port];
        m_a    = m_port ? req_a1 : req_a0;
        m_b    = m_port ? req_b1 : req_b0;
        m_res  = ref_alu(m_op, m_a, m_b);
        m_busy = 1;
        m_age  = 1;
      end
    end else if (m_age == 1) begin
      m_age  = 2;
      m_data = m_res;
    end else if (rsp_ready[m_port]) begin
      m_busy = 0;
    end
  end

  // Compare process: every out-of-reset cycle, DUT outputs against the model
  always @(negedge clk) begin
    if (!reset) begin
      logic [1:0] e_ready, e_valid;
      e_ready = 2'b00;
      e_valid = 2'b00;
      if (!m_busy && req_valid != 2'b00)
        e_ready = pick(req_valid, m_last) ? 2'b10 : 2'b01;
      if (m_busy && m_age == 2)
        e_valid = m_port ? 2'b10 : 2'b01;
      chk("req_ready", 16'(req_ready), 16'(e_ready));
      chk("rsp_valid", 16'(rsp_valid), 16'(e_valid));
      chk("rsp_data",  16'(rsp_data),  16'(m_data));
      chk("busy",      16'(busy),      16'(m_busy));
      chk("alu_ctrl",  16'(alu_ctrl),  16'(m_op));
      chk("alu_in1",   16'(alu_in1),   16'(m_a));
      chk("alu_in2",   16'(alu_in2),   16'(m_b));
    end
  end

  task automatic idle_inputs();
    req_valid = 2'b00; req_op = 2'b11; rsp_ready = 2'b11;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rsp_valid"}, 16'(rsp_valid), 16'h0);
    chk({tag, "_rsp_data"},  16'(rsp_data),  16'h0);
    chk({tag, "_alu_ctrl"},  16'(alu_ctrl),  16'h1);
    chk({tag, "_alu_in1"},   16'(alu_in1),   16'h0);
    chk({tag, "_alu_in2"},   16'(alu_in2),   16'h0);
    chk({tag, "_busy"},      16'(busy),      16'h0);
    chk({tag, "_req_ready"}, 16'(req_ready), 16'h0);
  endtask

  // One request on port p with rsp_ready held high; returns result and latency
  task automatic run_op(input bit p, input bit op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int lat);
    bit got;
    req_op[p] = op;
    if (p) begin req_a1 = a; req_b1 = b; end
    else   begin req_a0 = a; req_b0 = b; end
    rsp_ready = 2'b11;
    req_valid = p ? 2'b10 : 2'b01;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[p]) got = 1;
    end
    chk("grant_timeout", 16'(got), 16'h1);
    @(posedge clk); #1 req_valid = 2'b00;
    res = 8'h00; lat = -1; got = 0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid[p]) begin res = rsp_data; lat = n; got = 1; end
    end
    chk("rsp_timeout", 16'(got), 16'h1);
    @(posedge clk); #1;
  endtask

  // Both ports requesting continuously; collect the first four grants
  task automatic collect_grants(output logic [3:0] g, output int cnt);
    cnt = 0; g = 4'h0;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int i = 0; i < 40 && cnt < 4; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin g[cnt] = req_ready[1]; cnt++; end
    end
    @(posedge clk); #1 req_valid = 2'b00;
  endtask

  logic [7:0] res;
  int         lat, cnt;
  logic [3:0] grants;
  bit         got;

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_values("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Port 0 add, then multiplies on port 1 and an add that wraps
    run_op(1'b0, 1'b1, 8'd20, 8'd30, res, lat);
    chk("add_20_30", 16'(res), 16'd50);
    chk("add_latency", 16'(lat), 16'd2);
    run_op(1'b1, 1'b0, 8'h40, 8'h40, res, lat);
    chk("mul_40_40", 16'(res), 16'h20);
    run_op(1'b1, 1'b0, 8'h80, 8'h80, res, lat);
    chk("mul_80_80", 16'(res), 16'h80);
    run_op(1'b0, 1'b1, 8'd100, 8'd100, res, lat);
    chk("add_wrap", 16'(res), 16'hC8);

    // Grant order under continuous contention, fresh from reset
    do_reset();
    collect_grants(grants, cnt);
    chk("grant_count", 16'(cnt), 16'd4);
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("grant_order", 16'(grants), 16'b0000);
`else
    chk("grant_order", 16'(grants), 16'b1010);
`endif
    repeat (6) @(posedge clk);
    #1;

    // Response stalled for 5 cycles while the other port keeps requesting
    req_op[0] = 1'b1; req_a0 = 8'd7; req_b0 = 8'd9;
    rsp_ready = 2'b10;
    req_valid = 2'b01;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) got = 1;
    end
    chk("stall_rsp_timeout", 16'(got), 16'h1);
    @(posedge clk); #1 req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 16'(rsp_valid), 16'b01);
      chk("stall_rsp_data",  16'(rsp_data),  16'd16);
      chk("stall_req_ready", 16'(req_ready), 16'b00);
      chk("stall_busy",      16'(busy),      16'h1);
      if (i < 4) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1 rsp_ready = 2'b11;
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (6) @(posedge clk);
    #1;

    // Reset pulse while in EXEC discards the operation
    do_reset();
    req_op[1] = 1'b1; req_a1 = 8'd3; req_b1 = 8'd4;
    req_valid = 2'b10;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[1]) got = 1;
    end
    chk("exec_grant_timeout", 16'(got), 16'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    reset = 1'b1;
    #1 check_reset_values("midreset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_rsp_valid", 16'(rsp_valid), 16'h0);
    @(posedge clk); #1;
    collect_grants(grants, cnt);
    chk("post_reset_first_grant", 16'(grants[0]), 16'h0);
    repeat (6) @(posedge clk);
    #1;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 399) == 0) reset = 1'b1;
      if (reset) begin
        req_valid = 2'b00;
      end else begin
        req_valid = 2'($urandom_range(0, 3));
        req_op    = 2'($urandom_range(0, 3));
        req_a0    = 8'($urandom); req_b0 = 8'($urandom);
        req_a1    = 8'($urandom); req_b1 = 8'($urandom);
        rsp_ready = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
